// File: rtl/framebuffer_unpacker_pkg.sv
// Shared types and constants for the framebuffer unpacker: word/pixel geometry,
// the RGB565 pixel type, the lane index type and the unpacker state encoding.
package framebuffer_unpacker_pkg;

  localparam int FRAMEBUFFER_STREAM_WIDTH = 64;
  localparam int PIXEL_WIDTH              = 16;
  localparam int PIXELS_PER_WORD          = FRAMEBUFFER_STREAM_WIDTH / PIXEL_WIDTH;
  localparam int LANE_WIDTH               = $clog2(PIXELS_PER_WORD);

  typedef logic [PIXEL_WIDTH-1:0] rgb565_t;
  typedef logic [LANE_WIDTH-1:0] lane_t;
  typedef rgb565_t [PIXELS_PER_WORD-1:0] pixel_word_t;

  typedef enum logic {
    EMPTY,
    ACTIVE
  } unpack_state_e;

endpackage

// File: rtl/framebuffer_unpacker_if.sv
// Stream bundle around the unpacker: 64-bit framebuffer input and pixel output.
// 'slave' is the unpacker's view, 'master' is the producer/consumer environment's view.
interface framebuffer_unpacker_if;
  import framebuffer_unpacker_pkg::*;

  logic                                s_framebuffer_axis_tvalid;
  logic                                s_framebuffer_axis_tready;
  logic                                s_framebuffer_axis_tlast;
  logic [FRAMEBUFFER_STREAM_WIDTH-1:0] s_framebuffer_axis_tdata;

  logic    m_pixel_axis_tvalid;
  logic    m_pixel_axis_tready;
  logic    m_pixel_axis_tlast;
  logic    m_pixel_axis_tuser;
  rgb565_t m_pixel_axis_tdata;

  modport slave (
    input  s_framebuffer_axis_tvalid, s_framebuffer_axis_tlast, s_framebuffer_axis_tdata,
    output s_framebuffer_axis_tready,
    input  m_pixel_axis_tready,
    output m_pixel_axis_tvalid, m_pixel_axis_tlast, m_pixel_axis_tuser, m_pixel_axis_tdata
  );

  modport master (
    output s_framebuffer_axis_tvalid, s_framebuffer_axis_tlast, s_framebuffer_axis_tdata,
    input  s_framebuffer_axis_tready,
    output m_pixel_axis_tready,
    input  m_pixel_axis_tvalid, m_pixel_axis_tlast, m_pixel_axis_tuser, m_pixel_axis_tdata
  );

endinterface

// File: rtl/framebuffer_unpacker_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored.
module framebuffer_unpacker_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q;
  logic                  doPush, doPop;

  assign doPush = push_i && !full_q;
  assign doPop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + COUNT_ONE;
    end else if (doPop && !doPush) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  // Flags are registered from the next count so ready never depends on this cycle's pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == COUNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/framebuffer_unpacker.sv
// Splits buffered 64-bit framebuffer words into RGB565 pixels (lane 0 first) with
// frame/line markers. FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN enables tlast framing checks and sync_error.
module framebuffer_unpacker
  import framebuffer_unpacker_pkg::*;
#(
  parameter int X_RESOLUTION    = 640,
  parameter int Y_RESOLUTION    = 480,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic aclk,
  input  logic resetn,
  framebuffer_unpacker_if.slave bus,
  output logic frame_done
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  ,
  output logic sync_error
`endif
);

  localparam int XW = (X_RESOLUTION > 1) ? $clog2(X_RESOLUTION) : 1;
  localparam int YW = (Y_RESOLUTION > 1) ? $clog2(Y_RESOLUTION) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_RESOLUTION - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_RESOLUTION - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam lane_t LANE_LAST = lane_t'(PIXELS_PER_WORD - 1);
  localparam lane_t LANE_ONE  = lane_t'(1);
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  localparam int FIFO_W = FRAMEBUFFER_STREAM_WIDTH + 1;
`else
  localparam int FIFO_W = FRAMEBUFFER_STREAM_WIDTH;
`endif

  unpack_state_e     state_q, state_d;
  lane_t             lane_q, lane_d;
  pixel_word_t       word_q;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              frameDone_q, ready_q;
  logic [FIFO_W-1:0] fifoWdata, fifoRdata;
  logic              fifoFull, fifoEmpty, push, pop;
  logic              pixValid, pixXfer, laneEnd, atLastX, atFrameEnd, frameEnd;
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  logic              wordLast_q, syncErr_q, syncSet;
`endif

`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  assign fifoWdata = {bus.s_framebuffer_axis_tlast, bus.s_framebuffer_axis_tdata};
`else
  logic unusedTlast;
  assign unusedTlast = bus.s_framebuffer_axis_tlast;
  assign fifoWdata   = bus.s_framebuffer_axis_tdata;
`endif

  assign push = bus.s_framebuffer_axis_tvalid && bus.s_framebuffer_axis_tready;
  assign bus.s_framebuffer_axis_tready = ready_q && !fifoFull;

  framebuffer_unpacker_fifo #(
    .WIDTH      (FIFO_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_ni  (resetn),
    .push_i  (push),
    .wdata_i (fifoWdata),
    .pop_i   (pop),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign pixValid   = (state_q == ACTIVE);
  assign pixXfer    = pixValid && bus.m_pixel_axis_tready;
  assign laneEnd    = (lane_q == LANE_LAST);
  assign atLastX    = (x_q == X_LAST);
  assign atFrameEnd = atLastX && (y_q == Y_LAST);

  // Reload straight from the FIFO on the last lane so back-to-back words have no bubble.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    pop     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          lane_d  = '0;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pixXfer) begin
          if (!laneEnd) begin
            lane_d = lane_q + LANE_ONE;
          end else if (!fifoEmpty) begin
            pop    = 1'b1;
            lane_d = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    frameEnd = 1'b0;
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
    syncSet  = 1'b0;
`endif
    if (pixXfer) begin
      frameEnd = atFrameEnd;
      if (atLastX) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
      end else begin
        x_d = x_q + X_ONE;
      end
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
      // Early tlast restarts the frame; a missing tlast only flags the error.
      if (laneEnd && wordLast_q && !atFrameEnd) begin
        syncSet = 1'b1;
        x_d     = '0;
        y_d     = '0;
      end
      if (atFrameEnd && !wordLast_q) begin
        syncSet = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      lane_q      <= '0;
      word_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frameDone_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frameDone_q <= frameEnd;
      ready_q     <= 1'b1;
      if (pop) word_q <= pixel_word_t'(fifoRdata[FRAMEBUFFER_STREAM_WIDTH-1:0]);
    end
  end

`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wordLast_q <= 1'b0;
      syncErr_q  <= 1'b0;
    end else begin
      if (pop)     wordLast_q <= fifoRdata[FIFO_W-1];
      if (syncSet) syncErr_q  <= 1'b1;
    end
  end

  assign sync_error = syncErr_q;
`endif

  // Markers are gated by valid so every output reads zero while reset holds the datapath empty.
  assign bus.m_pixel_axis_tvalid = pixValid;
  assign bus.m_pixel_axis_tdata  = word_q[lane_q];
  assign bus.m_pixel_axis_tlast  = pixValid && atLastX;
  assign bus.m_pixel_axis_tuser  = pixValid && (x_q == '0) && (y_q == '0);
  assign frame_done              = frameDone_q;

endmodule

// File: tb/tb_framebuffer_unpacker.sv
// Directed bench for framebuffer_unpacker on a 16x4 frame; also covers the
// FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN build when that macro is defined.
module tb_framebuffer_unpacker;

  localparam int XR = 16;
  localparam int YR = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        endWord;
  } pix_t;

  logic aclk = 1'b0;
  logic resetn = 1'b1;
  logic frame_done;
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
  logic sync_error;
`endif

  framebuffer_unpacker_if bus ();

  framebuffer_unpacker #(
    .X_RESOLUTION    (XR),
    .Y_RESOLUTION    (YR),
    .FIFO_DEPTH_LOG2 (4)
  ) dut (
    .aclk       (aclk),
    .resetn     (resetn),
    .bus        (bus),
    .frame_done (frame_done)
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
    ,
    .sync_error (sync_error)
`endif
  );

  always #5 aclk = ~aclk;

  int compared = 0;
  int mismatched = 0;

  logic [63:0] srcData[$];
  logic        srcLast[$];
  pix_t        expPix[$];
  int mx, my, wordIdx, rxCount, tlastCount, doneCount, acceptCount, probeIdx;
  logic doneExp, expSync, probeUser, held;
  logic [15:0] heldData;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] makeWord(input logic [15:0] b);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic queueWord(input logic [63:0] w, input logic last);
    srcData.push_back(w);
    srcLast.push_back(last);
    wordIdx++;
  endtask

  // Plain frames: tlast on the final word of every 16-word frame.
  task automatic queueWords(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) queueWord(makeWord(base + 16'(4 * i)), (wordIdx % 16) == 15);
  endtask

  task automatic resetDut();
    bus.s_framebuffer_axis_tvalid = 1'b0;
    bus.s_framebuffer_axis_tlast  = 1'b0;
    bus.s_framebuffer_axis_tdata  = '0;
    bus.m_pixel_axis_tready       = 1'b0;
    resetn = 1'b0;
    srcData.delete(); srcLast.delete(); expPix.delete();
    mx = 0; my = 0; wordIdx = 0; rxCount = 0; tlastCount = 0; doneCount = 0;
    acceptCount = 0; doneExp = 1'b0; expSync = 1'b0; probeUser = 1'b0; held = 1'b0;
    probeIdx = -1;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    @(negedge aclk);
  endtask

  // Present the next queued word; an accepted word expands into four expected pixels.
  task automatic applyStimulus(input bit randomValid);
    logic [63:0] w;
    pix_t p;
    if (srcData.size() > 0 && (!randomValid || $urandom_range(0, 1) == 1)) begin
      w = srcData[0];
      bus.s_framebuffer_axis_tvalid = 1'b1;
      bus.s_framebuffer_axis_tdata  = w;
      bus.s_framebuffer_axis_tlast  = srcLast[0];
      if (bus.s_framebuffer_axis_tready) begin
        for (int l = 0; l < 4; l++) begin
          p.data    = w[16*l +: 16];
          p.endWord = srcLast[0] && (l == 3);
          expPix.push_back(p);
        end
        void'(srcData.pop_front());
        void'(srcLast.pop_front());
        acceptCount++;
      end
    end else begin
      bus.s_framebuffer_axis_tvalid = 1'b0;
    end
  endtask

  task automatic consumeStep(input bit randomReady);
    logic r;
    logic atEnd;
    pix_t p;
    checkOutput("frame_done", frame_done, doneExp);
    if (frame_done) doneCount++;
    doneExp = 1'b0;
    if (held) begin
      checkOutput("hold_valid", bus.m_pixel_axis_tvalid, 1'b1);
      checkOutput("hold_data", bus.m_pixel_axis_tdata, heldData);
    end
    r = randomReady ? ($urandom_range(0, 1) == 1) : 1'b1;
    bus.m_pixel_axis_tready = r;
    held = bus.m_pixel_axis_tvalid && !r;
    heldData = bus.m_pixel_axis_tdata;
    if (bus.m_pixel_axis_tvalid && r) begin
      if (expPix.size() == 0) begin
        checkOutput("unexpected_pixel", bus.m_pixel_axis_tdata, 64'hDEAD);
      end else begin
        p = expPix.pop_front();
        checkOutput("pixel_data", bus.m_pixel_axis_tdata, p.data);
        checkOutput("pixel_tuser", bus.m_pixel_axis_tuser, (mx == 0 && my == 0));
        checkOutput("pixel_tlast", bus.m_pixel_axis_tlast, (mx == XR - 1));
        if (bus.m_pixel_axis_tlast) tlastCount++;
        if (rxCount == probeIdx) probeUser = bus.m_pixel_axis_tuser;
        rxCount++;
        atEnd = (mx == XR - 1) && (my == YR - 1);
        if (mx == XR - 1) begin
          mx = 0;
          my = (my == YR - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
        doneExp = atEnd;
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
        if (p.endWord && !atEnd) begin
          expSync = 1'b1;
          mx = 0;
          my = 0;
        end
        if (atEnd && !p.endWord) expSync = 1'b1;
`endif
      end
    end
  endtask

  task automatic runStream(input int maxCycles, input bit randV, input bit randR);
    int cyc;
    cyc = 0;
    while ((srcData.size() > 0 || expPix.size() > 0 || doneExp) && cyc < maxCycles) begin
      @(negedge aclk);
      applyStimulus(randV);
      consumeStep(randR);
      cyc++;
    end
    checkOutput("stream_drained", (cyc < maxCycles), 1'b1);
    bus.s_framebuffer_axis_tvalid = 1'b0;
    bus.m_pixel_axis_tready = 1'b0;
  endtask

  task automatic checkSync();
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
    checkOutput("sync_error", sync_error, expSync);
`endif
  endtask

  initial begin
    bus.s_framebuffer_axis_tvalid = 1'b0;
    bus.s_framebuffer_axis_tlast  = 1'b0;
    bus.s_framebuffer_axis_tdata  = '0;
    bus.m_pixel_axis_tready       = 1'b0;

    // Reset state
    #1 resetn = 1'b0;
    #1;
    checkOutput("rst_s_tready", bus.s_framebuffer_axis_tready, 1'b0);
    checkOutput("rst_m_tvalid", bus.m_pixel_axis_tvalid, 1'b0);
    checkOutput("rst_m_tuser", bus.m_pixel_axis_tuser, 1'b0);
    checkOutput("rst_m_tlast", bus.m_pixel_axis_tlast, 1'b0);
    checkOutput("rst_m_tdata", bus.m_pixel_axis_tdata, 16'h0000);
    checkOutput("rst_frame_done", frame_done, 1'b0);
    resetDut();
    checkOutput("s_tready_after_reset", bus.s_framebuffer_axis_tready, 1'b1);
    checkSync();

    // Single word: two-cycle latency, then lanes 0..3 back to back
    bus.s_framebuffer_axis_tvalid = 1'b1;
    bus.s_framebuffer_axis_tdata  = 64'h4444_3333_2222_1111;
    bus.m_pixel_axis_tready       = 1'b1;
    @(negedge aclk);
    bus.s_framebuffer_axis_tvalid = 1'b0;
    checkOutput("latency_not_yet", bus.m_pixel_axis_tvalid, 1'b0);
    @(negedge aclk);
    checkOutput("first_valid", bus.m_pixel_axis_tvalid, 1'b1);
    checkOutput("first_pix", bus.m_pixel_axis_tdata, 16'h1111);
    checkOutput("first_tuser", bus.m_pixel_axis_tuser, 1'b1);
    @(negedge aclk);
    checkOutput("second_pix", bus.m_pixel_axis_tdata, 16'h2222);
    checkOutput("second_tuser", bus.m_pixel_axis_tuser, 1'b0);
    @(negedge aclk);
    checkOutput("third_pix", bus.m_pixel_axis_tdata, 16'h3333);
    @(negedge aclk);
    checkOutput("fourth_pix", bus.m_pixel_axis_tdata, 16'h4444);
    checkOutput("fourth_valid", bus.m_pixel_axis_tvalid, 1'b1);
    @(negedge aclk);
    checkOutput("drained_valid", bus.m_pixel_axis_tvalid, 1'b0);

    // Two full frames plus one word of the third
    resetDut();
    queueWords(33, 16'h1000);
    runStream(1000, 1'b0, 1'b0);
    checkOutput("frame_tlast_count", tlastCount, 8);
    checkOutput("frame_done_count", doneCount, 2);
    checkOutput("frame_pixel_count", rxCount, 132);
    checkSync();

    // Output stalled for 40 cycles: 16 words buffered plus one held
    resetDut();
    queueWords(20, 16'h0100);
    for (int c = 0; c < 40; c++) begin
      @(negedge aclk);
      bus.m_pixel_axis_tready = 1'b0;
      applyStimulus(1'b0);
      if (bus.m_pixel_axis_tvalid) begin
        checkOutput("stall_data", bus.m_pixel_axis_tdata, 16'h0100);
        checkOutput("stall_tuser", bus.m_pixel_axis_tuser, 1'b1);
      end
    end
    checkOutput("stall_accepted", acceptCount, 17);
    checkOutput("stall_s_tready", bus.s_framebuffer_axis_tready, 1'b0);
    checkOutput("stall_valid", bus.m_pixel_axis_tvalid, 1'b1);
    runStream(2000, 1'b0, 1'b0);
    checkOutput("stall_pixel_count", rxCount, 80);

    // Random backpressure on both sides over three frames
    resetDut();
    queueWords(48, 16'h2000);
    runStream(5000, 1'b1, 1'b1);
    checkOutput("random_tlast_count", tlastCount, 12);
    checkOutput("random_done_count", doneCount, 3);
    checkOutput("random_pixel_count", rxCount, 192);
    checkSync();

    // Premature tlast on the tenth word
    resetDut();
    for (int i = 0; i < 20; i++) queueWord(makeWord(16'h3000 + 16'(4 * i)), i == 9);
    probeIdx = 40;
    runStream(1000, 1'b0, 1'b0);
`ifdef FRAMEBUFFER_UNPACKER_SYNC_CHECK_EN
    checkOutput("sync_resync_tuser", probeUser, 1'b1);
    checkOutput("sync_sticky", sync_error, 1'b1);
    checkOutput("sync_tlast_count", tlastCount, 4);
    checkOutput("sync_done_count", doneCount, 0);
`else
    checkOutput("nosync_tuser", probeUser, 1'b0);
    checkOutput("nosync_tlast_count", tlastCount, 5);
    checkOutput("nosync_done_count", doneCount, 1);
`endif

    // Asynchronous reset mid-line
    resetDut();
    queueWords(8, 16'h5000);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      applyStimulus(1'b0);
      consumeStep(1'b0);
    end
    #2 resetn = 1'b0;
    #1;
    checkOutput("midrst_m_tvalid", bus.m_pixel_axis_tvalid, 1'b0);
    checkOutput("midrst_m_tdata", bus.m_pixel_axis_tdata, 16'h0000);
    checkOutput("midrst_m_tuser", bus.m_pixel_axis_tuser, 1'b0);
    checkOutput("midrst_m_tlast", bus.m_pixel_axis_tlast, 1'b0);
    checkOutput("midrst_s_tready", bus.s_framebuffer_axis_tready, 1'b0);
    checkOutput("midrst_frame_done", frame_done, 1'b0);
    resetDut();
    queueWords(1, 16'h7000);
    probeIdx = 0;
    runStream(200, 1'b0, 1'b0);
    checkOutput("midrst_first_tuser", probeUser, 1'b1);
    checkSync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
